// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// The slave modport is the unit; the master modport is the pipeline plus memory.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_fault;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_fault, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: byte-addressed load/store requests onto a word-wide memory,
// with sub-word extraction on loads and read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 64
) (
    input  logic                clk,
    input  logic                reset,
    load_store_unit_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WRITE,
        RESP
    } state_t;

    localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_WORDS);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              unsigned_q, unsigned_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       wdata_lo_q, wdata_lo_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_fault_q, resp_fault_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic [ADDR_W-1:0] req_index;
    logic              req_fault;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data;
    logic [31:0]       merged;

    assign req_index = bus.req_addr >> 2;
    assign req_fault = (bus.req_size == 2'b11)
                     || (bus.req_size == 2'b01 && bus.req_addr[0])
                     || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                     || (req_index >= MEM_LIMIT);

    // Lane extraction and merge both work on the word the memory returns during CAPTURE.
    always_comb begin
        byte_sel  = bus.mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel  = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        load_data = bus.mem_rdata;
        merged    = bus.mem_rdata;
        case (size_q)
            2'b00: begin
                load_data = unsigned_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                merged[{lane_q, 3'b000} +: 8] = wdata_lo_q[7:0];
            end
            2'b01: begin
                load_data = unsigned_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                if (lane_q[1]) merged[31:16] = wdata_lo_q;
                else           merged[15:0]  = wdata_lo_q;
            end
            default: begin
                load_data = bus.mem_rdata;
                merged    = bus.mem_rdata;
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        unsigned_d   = unsigned_q;
        lane_d       = lane_q;
        wdata_lo_d   = wdata_lo_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_fault_d = resp_fault_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d       = bus.req_we;
                    size_d     = bus.req_size;
                    unsigned_d = bus.req_unsigned;
                    lane_d     = bus.req_addr[1:0];
                    wdata_lo_d = bus.req_wdata[15:0];
                    if (req_fault) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'h0;
                        resp_fault_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        mem_addr_d = req_index;
                        state_d    = ISSUE;
                        // A word store is the only access that writes straight from ISSUE.
                        if (bus.req_we && bus.req_size == 2'b10) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = bus.req_wdata;
                        end
                    end
                end
            end
            ISSUE: begin
                if (we_q && size_q == 2'b10) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'h0;
                    resp_fault_d = 1'b0;
                    state_d      = RESP;
                end else begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (we_q) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merged;
                    state_d     = WRITE;
                end else begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                    resp_fault_d = 1'b0;
                    state_d      = RESP;
                end
            end
            WRITE: begin
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0;
                resp_fault_d = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            unsigned_q   <= 1'b0;
            lane_q       <= 2'b00;
            wdata_lo_q   <= 16'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_fault_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            unsigned_q   <= unsigned_d;
            lane_q       <= lane_d;
            wdata_lo_q   <= wdata_lo_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_fault_q <= resp_fault_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a 64-word synchronous memory model plus
// per-scenario tasks with hand-computed expected values.
module tb_load_store_unit;

    logic clk;
    logic reset;
    logic mem_preload;
    logic [31:0] mem [0:63];
    int vectors;
    int miscompares;

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .MEM_WORDS(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory: write and registered read on posedge, preload while mem_preload is high.
    always @(posedge clk) begin
        if (mem_preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[15] <= 32'hDEADBEEF;
            mem[63] <= 32'h0F0F0F0F;
            bus.mem_rdata <= 32'h0;
        end else begin
            if (bus.mem_we === 1'b1) mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr[5:0]];
        end
    end

    // One request, then eight cycles observed at negedge; cycle k means k cycles after accept.
    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int resp_cyc, output int resp_cnt, output logic [8:0] we_mask,
                           output logic [31:0] we_data, output logic [31:0] we_addr,
                           output logic [31:0] rdata, output logic fault);
        resp_cyc = -1;
        resp_cnt = 0;
        we_mask  = 9'h0;
        we_data  = 32'h0;
        we_addr  = 32'h0;
        rdata    = 32'hX;
        fault    = 1'bX;
        @(negedge clk);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ready_before_accept: got %b, expected 1", bus.req_ready);
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.mem_we !== 1'b0) begin
                we_mask[k] = 1'b1;
                we_data    = bus.mem_wdata;
                we_addr    = bus.mem_addr;
            end
            if (bus.resp_valid === 1'b1) begin
                resp_cnt++;
                if (resp_cyc < 0) begin
                    resp_cyc = k;
                    rdata    = bus.resp_rdata;
                    fault    = bus.resp_fault;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_preload = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b, expected 1", bus.req_ready);
        end
        vectors++;
        if ({bus.resp_valid, bus.resp_fault, bus.mem_we} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b, expected 000", {bus.resp_valid, bus.resp_fault, bus.mem_we});
        end
        vectors++;
        if ({bus.resp_rdata, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h, expected 0", {bus.resp_rdata, bus.mem_addr, bus.mem_wdata});
        end
        mem_preload = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load_word();
        int rc, rn;
        logic [8:0] wm;
        logic [31:0] wd, wa, rd;
        logic f;
        run_req(1'b0, 2'b10, 1'b0, 32'd60, 32'h0, rc, rn, wm, wd, wa, rd, f);
        vectors++;
        if (rc !== 3 || rn !== 1) begin
            miscompares++;
            $display("[TB] FAIL lw_latency: got cycle %0d count %0d, expected cycle 3 count 1", rc, rn);
        end
        vectors++;
        if (rd !== 32'hDEADBEEF || f !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lw_data: got %h fault %b, expected deadbeef fault 0", rd, f);
        end
        vectors++;
        if (wm !== 9'h0) begin
            miscompares++;
            $display("[TB] FAIL lw_no_write: got we mask %b, expected 0", wm);
        end
    endtask

    task automatic test_subword_loads();
        logic [1:0]  t_size [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
        logic        t_uns  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] t_addr [6] = '{32'd60, 32'd63, 32'd62, 32'd60, 32'd63, 32'd61};
        logic [31:0] t_exp  [6] = '{32'hFFFFFFEF, 32'h000000DE, 32'hFFFFDEAD,
                                    32'h0000BEEF, 32'hFFFFFFDE, 32'h000000BE};
        int rc, rn;
        logic [8:0] wm;
        logic [31:0] wd, wa, rd;
        logic f;
        for (int i = 0; i < 6; i++) begin
            run_req(1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, rc, rn, wm, wd, wa, rd, f);
            vectors++;
            if (rd !== t_exp[i] || f !== 1'b0 || rc !== 3 || wm !== 9'h0) begin
                miscompares++;
                $display("[TB] FAIL subload_%0d: got %h fault %b cycle %0d we %b, expected %h fault 0 cycle 3 we 0",
                         i, rd, f, rc, wm, t_exp[i]);
            end
        end
    endtask

    task automatic test_subword_store();
        int rc, rn;
        logic [8:0] wm;
        logic [31:0] wd, wa, rd;
        logic f;
        run_req(1'b1, 2'b00, 1'b0, 32'd61, 32'hAAAAAA55, rc, rn, wm, wd, wa, rd, f);
        vectors++;
        if (wm !== 9'h008) begin
            miscompares++;
            $display("[TB] FAIL sb_we_cycle: got we mask %b, expected 000001000", wm);
        end
        vectors++;
        if (wd !== 32'hDEAD55EF || wa !== 32'd15) begin
            miscompares++;
            $display("[TB] FAIL sb_write: got %h at %0d, expected dead55ef at 15", wd, wa);
        end
        vectors++;
        if (rc !== 4 || rn !== 1 || rd !== 32'h0 || f !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sb_resp: got cycle %0d count %0d data %h fault %b, expected 4 1 0 0", rc, rn, rd, f);
        end
        run_req(1'b0, 2'b10, 1'b0, 32'd60, 32'h0, rc, rn, wm, wd, wa, rd, f);
        vectors++;
        if (rd !== 32'hDEAD55EF || rc !== 3) begin
            miscompares++;
            $display("[TB] FAIL sb_readback: got %h cycle %0d, expected dead55ef cycle 3", rd, rc);
        end
        run_req(1'b1, 2'b01, 1'b0, 32'd6, 32'h1111CAFE, rc, rn, wm, wd, wa, rd, f);
        vectors++;
        if (wm !== 9'h008 || wd !== 32'hCAFE0000 || wa !== 32'd1 || rc !== 4) begin
            miscompares++;
            $display("[TB] FAIL sh_write: got we %b data %h addr %0d cycle %0d, expected 000001000 cafe0000 1 4",
                     wm, wd, wa, rc);
        end
        run_req(1'b0, 2'b01, 1'b1, 32'd6, 32'h0, rc, rn, wm, wd, wa, rd, f);
        vectors++;
        if (rd !== 32'h0000CAFE) begin
            miscompares++;
            $display("[TB] FAIL sh_readback: got %h, expected 0000cafe", rd);
        end
    endtask

    task automatic test_faults();
        logic [1:0]  t_size [4] = '{2'b10, 2'b10, 2'b11, 2'b01};
        logic [31:0] t_addr [4] = '{32'd62, 32'd256, 32'd0, 32'd61};
        int rc, rn;
        logic [8:0] wm;
        logic [31:0] wd, wa, rd;
        logic f;
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, 2'b10, 1'b0, 32'd60, 32'h0, rc, rn, wm, wd, wa, rd, f);
            run_req(i[0], t_size[i], 1'b0, t_addr[i], 32'hFFFFFFFF, rc, rn, wm, wd, wa, rd, f);
            vectors++;
            if (rc !== 1 || rn !== 1 || f !== 1'b1 || rd !== 32'h0 || wm !== 9'h0) begin
                miscompares++;
                $display("[TB] FAIL fault_%0d: got cycle %0d count %0d fault %b data %h we %b, expected 1 1 1 0 0",
                         i, rc, rn, f, rd, wm);
            end
        end
        run_req(1'b0, 2'b10, 1'b0, 32'd252, 32'h0, rc, rn, wm, wd, wa, rd, f);
        vectors++;
        if (rc !== 3 || f !== 1'b0 || rd !== 32'h0F0F0F0F) begin
            miscompares++;
            $display("[TB] FAIL last_word: got cycle %0d fault %b data %h, expected 3 0 0f0f0f0f", rc, f, rd);
        end
    endtask

    task automatic test_back_to_back();
        int rc;
        @(negedge clk);
        bus.req_we = 1'b1;
        bus.req_size = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd4;
        bus.req_wdata = 32'h12345678;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_we = 1'b0;
        bus.req_wdata = 32'h0;
        @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'd1 || bus.mem_wdata !== 32'h12345678 || bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sw_c1: got we %b addr %0d data %h ready %b, expected 1 1 12345678 0",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.req_ready);
        end
        @(negedge clk);
        vectors++;
        if (bus.resp_valid !== 1'b1 || bus.resp_fault !== 1'b0 || bus.mem_we !== 1'b0 || bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sw_c2: got resp %b fault %b we %b ready %b, expected 1 0 0 0",
                     bus.resp_valid, bus.resp_fault, bus.mem_we, bus.req_ready);
        end
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL sw_c3: got ready %b resp %b, expected 1 0", bus.req_ready, bus.resp_valid);
        end
        @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b0 || bus.mem_addr !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL sw_next_accept: got ready %b addr %0d, expected 0 1", bus.req_ready, bus.mem_addr);
        end
        bus.req_valid = 1'b0;
        rc = -1;
        for (int k = 5; k <= 8; k++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1 && rc < 0) begin
                rc = k;
                vectors++;
                if (bus.resp_rdata !== 32'h12345678) begin
                    miscompares++;
                    $display("[TB] FAIL sw_readback: got %h, expected 12345678", bus.resp_rdata);
                end
            end
        end
        vectors++;
        if (rc !== 6) begin
            miscompares++;
            $display("[TB] FAIL sw_next_latency: got cycle %0d, expected 6", rc);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        int bad;
        @(negedge clk);
        bus.req_we = 1'b1;
        bus.req_size = 2'b01;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'd60;
        bus.req_wdata = 32'h00001234;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_fault, bus.mem_we} !== 4'b1000 ||
            {bus.resp_rdata, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_midop_outputs: got rdy/rv/rf/we %b data %h, expected 1000 and 0",
                     {bus.req_ready, bus.resp_valid, bus.resp_fault, bus.mem_we},
                     {bus.resp_rdata, bus.mem_addr, bus.mem_wdata});
        end
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.mem_we !== 1'b0 || bus.resp_valid !== 1'b0) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("[TB] FAIL reset_midop_quiet: got %0d active cycles, expected 0", bad);
        end
        vectors++;
        if (mem[15] !== 32'hDEAD55EF) begin
            miscompares++;
            $display("[TB] FAIL reset_midop_mem: got %h, expected dead55ef", mem[15]);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_load_word();
        test_subword_loads();
        test_subword_store();
        test_faults();
        test_back_to_back();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
